id_ex_stage: RTL and testbench

- ID/EX pipeline register that sits directly upstream of the ALU.
- Captures decoded operands and control from the decode stage, decodes funct3/funct7 into the 3-bit ALU operation code, and selects the immediate or rs2 for operand b.
- Applies EX/MEM and MEM/WB forwarding to the held operands.
- Presents a, b and aluOp to the ALU under a valid/ready handshake, with stall and flush support.

---
 rtl/id_ex_stage.sv | 128 ++++++++++++
 tb/tb_id_ex_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes the ALU op, holds operands under a valid/ready
// handshake and applies EX/MEM and MEM/WB forwarding to the held sources.
module id_ex_stage #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          FWD_EN = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] rs1Data,
    input  logic [WIDTH-1:0] rs2Data,
    input  logic [WIDTH-1:0] imm,
    input  logic [4:0]       rs1Addr,
    input  logic [4:0]       rs2Addr,
    input  logic [4:0]       rdAddr,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             useImm,
    input  logic             regWrite,
    input  logic             flush,
    input  logic             exmemRegWrite,
    input  logic [4:0]       exmemRd,
    input  logic [WIDTH-1:0] exmemResult,
    input  logic             memwbRegWrite,
    input  logic [4:0]       memwbRd,
    input  logic [WIDTH-1:0] memwbResult,
    input  logic             outReady,
    output logic             outValid,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [2:0]       aluOp,
    output logic [4:0]       outRd,
    output logic             outRegWrite,
    output logic             illegal,
    output logic [CNT_W-1:0] issueCount
);

    logic             valid_q;
    logic [WIDTH-1:0] rs1_q, rs2_q, imm_q;
    logic [4:0]       rs1a_q, rs2a_q, rd_q;
    logic             use_imm_q, regwrite_q, illegal_q;
    logic [2:0]       aluop_q;
    logic [CNT_W-1:0] cnt_q;

    logic [2:0]       aluop_d;
    logic             illegal_d;
    logic             capture;
    logic [WIDTH-1:0] fwd1, fwd2;

    assign inReady = !valid_q || outReady;
    assign capture = inValid && inReady && !flush;

    always_comb begin
        aluop_d   = 3'b000;
        illegal_d = 1'b0;
        case (funct3)
            3'b000: aluop_d = (funct7b5 && !useImm) ? 3'b001 : 3'b000;
            3'b111: aluop_d = 3'b010;
            3'b110: aluop_d = 3'b011;
            3'b100: aluop_d = 3'b100;
            3'b001: begin
                if (funct7b5) illegal_d = 1'b1;
                else          aluop_d   = 3'b101;
            end
            default: illegal_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            rs1a_q     <= '0;
            rs2a_q     <= '0;
            rd_q       <= '0;
            use_imm_q  <= 1'b0;
            regwrite_q <= 1'b0;
            illegal_q  <= 1'b0;
            aluop_q    <= 3'b000;
            cnt_q      <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (capture) begin
                valid_q    <= 1'b1;
                rs1_q      <= rs1Data;
                rs2_q      <= rs2Data;
                imm_q      <= imm;
                rs1a_q     <= rs1Addr;
                rs2a_q     <= rs2Addr;
                rd_q       <= rdAddr;
                use_imm_q  <= useImm;
                regwrite_q <= regWrite && !illegal_d;
                illegal_q  <= illegal_d;
                aluop_q    <= aluop_d;
            end else if (outReady) begin
                valid_q <= 1'b0;
            end
            if (capture && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Forwarding tracks the held indices every cycle so a late writeback lands during a stall.
    always_comb begin
        fwd1 = rs1_q;
        fwd2 = rs2_q;
        if (FWD_EN) begin
            if (exmemRegWrite && exmemRd == rs1a_q && rs1a_q != 5'd0)      fwd1 = exmemResult;
            else if (memwbRegWrite && memwbRd == rs1a_q && rs1a_q != 5'd0) fwd1 = memwbResult;
            if (exmemRegWrite && exmemRd == rs2a_q && rs2a_q != 5'd0)      fwd2 = exmemResult;
            else if (memwbRegWrite && memwbRd == rs2a_q && rs2a_q != 5'd0) fwd2 = memwbResult;
        end
    end

    assign outValid    = valid_q;
    assign a           = valid_q ? fwd1 : '0;
    assign b           = !valid_q ? '0 : (use_imm_q ? imm_q : fwd2);
    assign aluOp       = aluop_q;
    assign outRd       = rd_q;
    assign outRegWrite = regwrite_q;
    assign illegal     = illegal_q;
    assign issueCount  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, forwarding, stall, flush, reset and streaming.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValid, inReady, inReady_s;
    logic [31:0] rs1Data, rs2Data, imm;
    logic [4:0]  rs1Addr, rs2Addr, rdAddr;
    logic [2:0]  funct3;
    logic        funct7b5, useImm, regWrite, flush;
    logic        exmemRegWrite, memwbRegWrite;
    logic [4:0]  exmemRd, memwbRd;
    logic [31:0] exmemResult, memwbResult;
    logic        outReady;
    logic        outValid, outRegWrite, illegal;
    logic [31:0] a, b;
    logic [2:0]  aluOp;
    logic [4:0]  outRd;
    logic [15:0] issueCount;
    logic        outValid_s, outRegWrite_s, illegal_s;
    logic [31:0] a_s, b_s;
    logic [2:0]  aluOp_s;
    logic [4:0]  outRd_s;
    logic [1:0]  issueCount_s;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.WIDTH(32), .FWD_EN(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
        .rs1Data(rs1Data), .rs2Data(rs2Data), .imm(imm),
        .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rdAddr(rdAddr),
        .funct3(funct3), .funct7b5(funct7b5), .useImm(useImm), .regWrite(regWrite),
        .flush(flush), .exmemRegWrite(exmemRegWrite), .exmemRd(exmemRd),
        .exmemResult(exmemResult), .memwbRegWrite(memwbRegWrite), .memwbRd(memwbRd),
        .memwbResult(memwbResult), .outReady(outReady), .outValid(outValid),
        .a(a), .b(b), .aluOp(aluOp), .outRd(outRd), .outRegWrite(outRegWrite),
        .illegal(illegal), .issueCount(issueCount)
    );

    // Unforwarded, narrow-counter variant driven by the same stimulus.
    id_ex_stage #(.WIDTH(32), .FWD_EN(1'b0), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady_s),
        .rs1Data(rs1Data), .rs2Data(rs2Data), .imm(imm),
        .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rdAddr(rdAddr),
        .funct3(funct3), .funct7b5(funct7b5), .useImm(useImm), .regWrite(regWrite),
        .flush(flush), .exmemRegWrite(exmemRegWrite), .exmemRd(exmemRd),
        .exmemResult(exmemResult), .memwbRegWrite(memwbRegWrite), .memwbRd(memwbRd),
        .memwbResult(memwbResult), .outReady(outReady), .outValid(outValid_s),
        .a(a_s), .b(b_s), .aluOp(aluOp_s), .outRd(outRd_s), .outRegWrite(outRegWrite_s),
        .illegal(illegal_s), .issueCount(issueCount_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0] f3;
        logic       f7;
        logic [2:0] op;
        logic       ill;
    } dec_vec_t;

    dec_vec_t dec_tab[7] = '{
        '{3'b111, 1'b0, 3'b010, 1'b0},
        '{3'b110, 1'b0, 3'b011, 1'b0},
        '{3'b100, 1'b0, 3'b100, 1'b0},
        '{3'b001, 1'b0, 3'b101, 1'b0},
        '{3'b001, 1'b1, 3'b000, 1'b1},
        '{3'b101, 1'b0, 3'b000, 1'b1},
        '{3'b011, 1'b0, 3'b000, 1'b1}
    };

    initial begin
        rst_n = 1'b0; inValid = 1'b0; rs1Data = '0; rs2Data = '0; imm = '0;
        rs1Addr = '0; rs2Addr = '0; rdAddr = '0; funct3 = '0; funct7b5 = 1'b0;
        useImm = 1'b0; regWrite = 1'b0; flush = 1'b0;
        exmemRegWrite = 1'b0; exmemRd = '0; exmemResult = '0;
        memwbRegWrite = 1'b0; memwbRd = '0; memwbResult = '0; outReady = 1'b0;
        #12;
        check("rst_outValid", 32'(outValid), 32'd0);
        check("rst_aluOp", 32'(aluOp), 32'd0);
        check("rst_count", 32'(issueCount), 32'd0);
        check("rst_ab", a | b, 32'd0);
        check("rst_flags", {29'd0, illegal, outRegWrite, |outRd}, 32'd0);
        rst_n = 1'b1;

        // ADD
        inValid = 1'b1; outReady = 1'b1; regWrite = 1'b1;
        rs1Addr = 5'd1; rs2Addr = 5'd2; rdAddr = 5'd4; rs1Data = 32'd5; rs2Data = 32'd7;
        check("empty_inReady", 32'(inReady), 32'd1);
        step(); exp_cnt++;
        check("add_valid", 32'(outValid), 32'd1);
        check("add_a", a, 32'd5);
        check("add_b", b, 32'd7);
        check("add_op", 32'(aluOp), 32'd0);
        check("add_rd", 32'(outRd), 32'd4);
        check("add_cnt", 32'(issueCount), 32'd1);

        // SUB then I-type with funct7b5 set
        funct7b5 = 1'b1; rs1Data = 32'd10; rs2Data = 32'd3;
        step(); exp_cnt++;
        check("sub_op", 32'(aluOp), 32'd1);
        check("sub_b", b, 32'd3);
        useImm = 1'b1; imm = 32'hFFFF_FFFC; rs2Data = 32'd9;
        step(); exp_cnt++;
        check("itype_op", 32'(aluOp), 32'd0);
        check("itype_b", b, 32'hFFFF_FFFC);
        check("itype_cnt", 32'(issueCount), 32'(exp_cnt));
        useImm = 1'b0;

        // Remaining decodes, back-to-back
        foreach (dec_tab[i]) begin
            funct3 = dec_tab[i].f3; funct7b5 = dec_tab[i].f7;
            step(); exp_cnt++;
            check("dec_op", 32'(aluOp), 32'(dec_tab[i].op));
            check("dec_illegal", 32'(illegal), 32'(dec_tab[i].ill));
            check("dec_regwrite", 32'(outRegWrite), 32'(!dec_tab[i].ill));
        end

        // Forwarding priority
        funct3 = 3'b000; funct7b5 = 1'b0;
        rs1Addr = 5'd3; rs1Data = 32'h11; rs2Addr = 5'd5; rs2Data = 32'h22;
        step(); exp_cnt++;
        inValid = 1'b0; outReady = 1'b0;
        exmemRegWrite = 1'b1; exmemRd = 5'd3; exmemResult = 32'hAA;
        memwbRegWrite = 1'b1; memwbRd = 5'd3; memwbResult = 32'hBB;
        #1;
        check("fwd_exmem", a, 32'hAA);
        check("fwd_b_nomatch", b, 32'h22);
        check("fwd_disabled", a_s, 32'h11);
        exmemRegWrite = 1'b0;
        #1;
        check("fwd_memwb", a, 32'hBB);
        exmemRegWrite = 1'b0; memwbRegWrite = 1'b0;
        inValid = 1'b1; outReady = 1'b1; rs1Addr = 5'd0; rs1Data = 32'h33;
        step(); exp_cnt++;
        inValid = 1'b0; outReady = 1'b0;
        exmemRegWrite = 1'b1; exmemRd = 5'd0; memwbRegWrite = 1'b1; memwbRd = 5'd0;
        #1;
        check("fwd_x0", a, 32'h33);
        exmemRegWrite = 1'b0; memwbRegWrite = 1'b0;

        // Stall with a late MEM/WB forward onto rs2
        inValid = 1'b1; outReady = 1'b1;
        rs1Addr = 5'd1; rs1Data = 32'd1; rs2Addr = 5'd6; rs2Data = 32'h44;
        step(); exp_cnt++;
        outReady = 1'b0; rs1Data = 32'h99; rs2Data = 32'h98;
        for (int c = 1; c <= 3; c++) begin
            if (c == 2) begin
                memwbRegWrite = 1'b1; memwbRd = 5'd6; memwbResult = 32'h55;
            end
            #1;
            check("stall_inReady", 32'(inReady), 32'd0);
            check("stall_valid", 32'(outValid), 32'd1);
            check("stall_a", a, 32'd1);
            check("stall_b", b, (c == 1) ? 32'h44 : 32'h55);
            check("stall_cnt", 32'(issueCount), 32'(exp_cnt));
            step();
        end
        memwbRegWrite = 1'b0; inValid = 1'b0; outReady = 1'b1;
        #1;
        check("stall_held_b", b, 32'h44);
        step();
        check("drain_valid", 32'(outValid), 32'd0);
        check("drain_ab", a | b, 32'd0);

        // Illegal op then flush against a new capture
        inValid = 1'b1; funct3 = 3'b010; regWrite = 1'b1;
        step(); exp_cnt++;
        check("ill_illegal", 32'(illegal), 32'd1);
        check("ill_regwrite", 32'(outRegWrite), 32'd0);
        check("ill_op", 32'(aluOp), 32'd0);
        flush = 1'b1; funct3 = 3'b000;
        step();
        check("flush_valid", 32'(outValid), 32'd0);
        check("flush_cnt", 32'(issueCount), 32'(exp_cnt));
        flush = 1'b0;

        // Asynchronous reset in the middle of a stall
        step(); exp_cnt++;
        inValid = 1'b0; outReady = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(outValid), 32'd0);
        check("arst_cnt", 32'(issueCount), 32'd0);
        check("arst_rd", 32'(outRd), 32'd0);
        #3 rst_n = 1'b1;
        exp_cnt = 0;

        // Back-to-back stream of 10
        inValid = 1'b1; outReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rs1Data = 32'(100 + i);
            step(); exp_cnt++;
            check("stream_valid", 32'(outValid), 32'd1);
            check("stream_a", a, 32'(100 + i));
        end
        inValid = 1'b0;
        check("stream_cnt", 32'(issueCount), 32'd10);
        check("sat_cnt", 32'(issueCount_s), 32'd3);
        step();
        check("stream_end", 32'(outValid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
